// File: rtl/tone_synth_pkg.sv
// rtl/tone_synth_pkg.sv - Note tables, state types and pitch helpers for the polyphonic tone synthesiser
package tone_synth_pkg;

    localparam int HP_W = 16;

    typedef enum logic [3:0] {
        NOTE_SILENT = 4'd0,
        NOTE_C      = 4'd1,
        NOTE_CS     = 4'd2,
        NOTE_D      = 4'd3,
        NOTE_DS     = 4'd4,
        NOTE_E      = 4'd5,
        NOTE_F      = 4'd6,
        NOTE_FS     = 4'd7,
        NOTE_G      = 4'd8,
        NOTE_GS     = 4'd9,
        NOTE_A      = 4'd10,
        NOTE_AS     = 4'd11,
        NOTE_B      = 4'd12
    } note_e;

    typedef enum logic {
        CH_SILENT = 1'b0,
        CH_RUN    = 1'b1
    } chan_state_e;

    // Octave-4 half-periods in cycles of the 10 MHz system clock
    localparam logic [HP_W-1:0] HP_TABLE [12] = '{
        16'd19111, 16'd18039, 16'd17026, 16'd16071, 16'd15169, 16'd14317,
        16'd13514, 16'd12755, 16'd12039, 16'd11364, 16'd10726, 16'd10124
    };

    localparam logic [6:0] LED_TABLE [12] = '{
        7'h01, 7'h03, 7'h02, 7'h06, 7'h04, 7'h08,
        7'h18, 7'h10, 7'h30, 7'h20, 7'h60, 7'h40
    };

    function automatic logic note_valid(input logic [3:0] code);
        return (code >= NOTE_C) && (code <= NOTE_B);
    endfunction

    function automatic logic [3:0] note_index(input logic [3:0] code);
        return code - NOTE_C;
    endfunction

    function automatic logic [HP_W-1:0] half_period(input logic [3:0] code,
                                                     input logic [1:0] octave);
        if (!note_valid(code)) begin
            return '0;
        end
        return HP_TABLE[note_index(code)] >> octave;
    endfunction

    function automatic logic [6:0] led_pattern(input logic [3:0] code);
        if (!note_valid(code)) begin
            return '0;
        end
        return LED_TABLE[note_index(code)];
    endfunction

endpackage

// File: rtl/tone_chan.sv
// rtl/tone_chan.sv - One square-wave channel: request register, half-period divider and glitch-free pitch reload
module tone_chan
    import tone_synth_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] note,
    input  logic [1:0] octave,
    output logic       tone,
    output logic       tone_edge,
    output logic       run_nxt,
    output logic [6:0] led_nxt
);

    logic [3:0]       req_note_q, req_note_d;
    logic [1:0]       req_oct_q, req_oct_d;
    chan_state_e      state_q, state_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             tone_q, tone_d;
    logic             edge_q, edge_d;
    logic [6:0]       led_q, led_d;

    logic             req_valid;
    logic [DIV_W-1:0] target;
    logic             boundary;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_note_q <= '0;
            req_oct_q  <= '0;
            state_q    <= CH_SILENT;
            act_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            tone_q     <= 1'b0;
            edge_q     <= 1'b0;
            led_q      <= '0;
        end else begin
            req_note_q <= req_note_d;
            req_oct_q  <= req_oct_d;
            state_q    <= state_d;
            act_q      <= act_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            tone_q     <= tone_d;
            edge_q     <= edge_d;
            led_q      <= led_d;
        end
    end

    always_comb begin
        req_note_d = note;
        req_oct_d  = octave;
        state_d    = state_q;
        act_d      = act_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        tone_d     = tone_q;
        edge_d     = 1'b0;
        led_d      = led_q;

        req_valid = note_valid(req_note_q);
        target    = DIV_W'(half_period(req_note_q, req_oct_q));
        boundary  = (cnt_q == act_q - DIV_W'(1));

        case (state_q)
            CH_SILENT: begin
                cnt_d  = '0;
                tone_d = 1'b0;
                pend_d = 1'b0;
                act_d  = '0;
                led_d  = '0;
                if (req_valid) begin
                    state_d = CH_RUN;
                    act_d   = target;
                    led_d   = led_pattern(req_note_q);
                end
            end
            CH_RUN: begin
                if (boundary) begin
                    tone_d = ~tone_q;
                    edge_d = 1'b1;
                    cnt_d  = '0;
                    // Silence only lands on a falling edge; a rising edge keeps the old pitch one more half-period
                    if (pend_q || (!req_valid && tone_q)) begin
                        state_d = CH_SILENT;
                        act_d   = '0;
                        led_d   = '0;
                        pend_d  = 1'b0;
                    end else if (!req_valid) begin
                        pend_d = 1'b1;
                    end else begin
                        act_d = target;
                        led_d = led_pattern(req_note_q);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = CH_SILENT;
            end
        endcase
    end

    assign tone      = tone_q;
    assign tone_edge = edge_q;
    assign run_nxt   = (state_d == CH_RUN);
    assign led_nxt   = led_d;

endmodule

// File: rtl/tone_synth_poly.sv
// rtl/tone_synth_poly.sv - Polyphonic square-wave tone generator with mix level and combined LED pattern
module tone_synth_poly
    import tone_synth_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16,
    parameter int MIX_W  = $clog2(NUM_CH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH*4-1:0]   note,
    input  logic [NUM_CH*2-1:0]   octave,
    output logic [NUM_CH-1:0]     tone,
    output logic [NUM_CH-1:0]     tone_edge,
    output logic [MIX_W-1:0]      mix,
    output logic [7:0]            note_leds
);

    logic [NUM_CH-1:0] run_nxt;
    logic [6:0]        led_nxt [NUM_CH];

    logic [MIX_W-1:0]  mix_q, mix_d;
    logic [7:0]        leds_q, leds_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        tone_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .note      (note[g*4 +: 4]),
            .octave    (octave[g*2 +: 2]),
            .tone      (tone[g]),
            .tone_edge (tone_edge[g]),
            .run_nxt   (run_nxt[g]),
            .led_nxt   (led_nxt[g])
        );
    end

    // LEDs use the channels' next state so they register alongside act
    always_comb begin
        mix_d  = '0;
        leds_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mix_d       = mix_d + MIX_W'(tone[i]);
            leds_d[6:0] = leds_d[6:0] | led_nxt[i];
        end
        leds_d[7] = |run_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mix_q  <= '0;
            leds_q <= '0;
        end else begin
            mix_q  <= mix_d;
            leds_q <= leds_d;
        end
    end

    assign mix       = mix_q;
    assign note_leds = leds_q;

endmodule

// File: tb/tb_tone_synth_poly.sv
// tb/tb_tone_synth_poly.sv - Self-checking bench for tone_synth_poly with an event-time reference model
module tb_tone_synth_poly;

    localparam int NCH = 4;
    localparam int MW  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH*4-1:0] note = '0;
    logic [NCH*2-1:0] octave = '0;
    logic [NCH-1:0]   tone;
    logic [NCH-1:0]   tone_edge;
    logic [MW-1:0]    mix;
    logic [7:0]       note_leds;

    tone_synth_poly #(
        .NUM_CH (NCH),
        .DIV_W  (16),
        .MIX_W  (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .note      (note),
        .octave    (octave),
        .tone      (tone),
        .tone_edge (tone_edge),
        .mix       (mix),
        .note_leds (note_leds)
    );

    always #50 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit done   = 0;

    int HP[12]   = '{19111, 18039, 17026, 16071, 15169, 14317,
                     13514, 12755, 12039, 11364, 10726, 10124};
    int LEDT[12] = '{'h01, 'h03, 'h02, 'h06, 'h04, 'h08,
                     'h18, 'h10, 'h30, 'h20, 'h60, 'h40};

    function automatic int target(input logic [3:0] n, input logic [1:0] o);
        if (n < 1 || n > 12) return 0;
        return HP[n-1] >> o;
    endfunction

    function automatic int led_of(input logic [3:0] n);
        if (n < 1 || n > 12) return 0;
        return LEDT[n-1];
    endfunction

    // Reference model: each sounding channel schedules its next toggle as an absolute cycle number
    logic [3:0] m_req_n [NCH];
    logic [1:0] m_req_o [NCH];
    bit         m_sound [NCH];
    bit         m_tone  [NCH];
    bit         m_edge  [NCH];
    bit         m_pend  [NCH];
    int         m_hp    [NCH];
    int         m_next  [NCH];
    int         m_led   [NCH];
    int         m_mix = 0;

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_req_n[c] = '0; m_req_o[c] = '0; m_sound[c] = 0; m_tone[c] = 0;
            m_edge[c] = 0; m_pend[c] = 0; m_hp[c] = 0; m_next[c] = 0; m_led[c] = 0;
        end
    end

    always @(posedge clk) begin
        int ones;
        int tg;
        cyc++;
        ones = 0;
        for (int c = 0; c < NCH; c++) ones += int'(m_tone[c]);
        for (int c = 0; c < NCH; c++) begin
            m_edge[c] = 0;
            if (rst) begin
                m_sound[c] = 0; m_tone[c] = 0; m_pend[c] = 0; m_hp[c] = 0;
                m_led[c] = 0; m_next[c] = 0; m_req_n[c] = '0; m_req_o[c] = '0;
            end else begin
                tg = target(m_req_n[c], m_req_o[c]);
                if (!m_sound[c]) begin
                    if (tg != 0) begin
                        m_sound[c] = 1;
                        m_hp[c]    = tg;
                        m_next[c]  = cyc + tg;
                        m_led[c]   = led_of(m_req_n[c]);
                    end
                end else if (cyc == m_next[c]) begin
                    m_tone[c] = !m_tone[c];
                    m_edge[c] = 1;
                    if (m_pend[c] || (tg == 0 && !m_tone[c])) begin
                        m_sound[c] = 0; m_pend[c] = 0; m_led[c] = 0;
                    end else if (tg == 0) begin
                        m_pend[c] = 1;
                        m_next[c] = cyc + m_hp[c];
                    end else begin
                        m_hp[c]   = tg;
                        m_led[c]  = led_of(m_req_n[c]);
                        m_next[c] = cyc + tg;
                    end
                end
                m_req_n[c] = note[c*4 +: 4];
                m_req_o[c] = octave[c*2 +: 2];
            end
        end
        m_mix = rst ? 0 : ones;
    end

    task automatic finish_sim();
        if (done) return;
        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    always @(negedge clk) begin
        if (cyc > 0 && !done) begin
            logic [NCH-1:0] et;
            logic [NCH-1:0] ee;
            logic [7:0]     el;
            logic [MW-1:0]  em;
            el = '0;
            for (int c = 0; c < NCH; c++) begin
                et[c]    = m_tone[c];
                ee[c]    = m_edge[c];
                el[6:0]  = el[6:0] | 7'(m_led[c]);
                el[7]    = el[7] | m_sound[c];
            end
            em = MW'(m_mix);
            checks++;
            if ({tone, tone_edge, mix, note_leds} !== {et, ee, em, el}) begin
                errors++;
                $display("FAIL model_cmp cyc=%0d tone=%b exp=%b edge=%b exp=%b mix=%0d exp=%0d leds=%h exp=%h",
                         cyc, tone, et, tone_edge, ee, mix, em, note_leds, el);
            end
            if (errors > 40) finish_sim();
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
        if (errors > 40) finish_sim();
    endtask

    task automatic wait_edge(input int ch, input logic lvl, output int t);
        int n;
        n = 0;
        t = -1;
        while (n < 25000) begin
            @(negedge clk);
            if (tone_edge[ch] === 1'b1 && tone[ch] === lvl) begin
                t = cyc;
                return;
            end
            n++;
        end
        checks++;
        errors++;
        $display("FAIL wait_edge ch%0d level %0d timeout", ch, lvl);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tone"}, tone, 0);
        check({tag, "_edge"}, tone_edge, 0);
        check({tag, "_mix"}, mix, 0);
        check({tag, "_leds"}, note_leds, 0);
    endtask

    initial begin
        #(12_000_000);
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        errors++;
        finish_sim();
    end

    initial begin
        int t0, t1, t2, t3, rises;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // C7 on ch0, then silence requested during a high phase
        @(posedge clk); #1 note[3:0] = 4'd1; octave[1:0] = 2'd3; t0 = cyc;
        wait_edge(0, 1'b1, t1);
        check("c7_first_rise", t1 - t0, 2390);
        check("c7_leds", note_leds, 'h81);
        wait_edge(0, 1'b0, t2);
        check("c7_half", t2 - t1, 2388);
        wait_edge(0, 1'b1, t3);
        check("c7_period", t3 - t1, 4776);
        repeat (100) @(posedge clk);
        #1 note[3:0] = 4'd0;
        wait_edge(0, 1'b0, t2);
        check("silence_fall", t2 - t3, 2388);
        rises = 0;
        repeat (3000) begin
            @(negedge clk);
            if (tone[0] !== 1'b0) rises++;
        end
        check("silence_stays_low", rises, 0);
        check("silence_leds", note_leds, 0);

        // A4 on ch0, then switch to B mid-half-period
        @(posedge clk); #1 note[3:0] = 4'd10; octave[1:0] = 2'd0; t0 = cyc;
        wait_edge(0, 1'b1, t1);
        check("a4_first_rise", t1 - t0, 11366);
        check("a4_leds", note_leds, 'ha0);
        repeat (5000) @(posedge clk);
        #1 note[3:0] = 4'd12;
        wait_edge(0, 1'b0, t2);
        check("chg_cur_half", t2 - t1, 11364);
        wait_edge(0, 1'b1, t3);
        check("chg_next_half", t3 - t2, 10124);
        check("chg_leds", note_leds, 'hc0);

        // Reset while ch0 runs, then all channels start together
        @(posedge clk); #1 rst = 1'b1; note = {NCH{4'd1}}; octave = '0;
        @(posedge clk);
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk); #1 rst = 1'b0; t0 = cyc;
        wait_edge(0, 1'b1, t1);
        check("all_first_rise", t1 - t0, 19113);
        check("all_tone", tone, 'hf);
        check("all_edge", tone_edge, 'hf);
        @(negedge clk);
        check("all_mix_high", mix, 4);
        check("all_leds", note_leds, 'h81);

        // Reset with every channel running, release with the same notes
        repeat (100) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("allrst");
        @(posedge clk); #1 rst = 1'b0; t0 = cyc;
        wait_edge(0, 1'b1, t1);
        check("rerun_first_rise", t1 - t0, 19113);
        check("rerun_tone", tone, 'hf);

        finish_sim();
    end

endmodule
